gpio_io_unit: RTL and testbench
===============================

# gpio_io_unit

- Sits between the multicycle datapath and the board pins, on both sides of the datapath's GPIO ports.
- Output side: latches the datapath's 8-bit ALU result into a registered output port.
- Input side: synchronizes and debounces the raw input pins, then presents them to the datapath's 8-bit GPIO input.
- Also flags input changes and produces the divided `clk_signal` square wave plus a single-cycle `tick_o` for slow board-level display.

## Interface
Parameters:
- `DATA_W`, 8, GPIO width in both directions.
- `DEB_CYCLES`, 16, consecutive stable cycles required to accept an input change; ≥2.
- `DIV_MAX`, 25_000_000, clk cycles per half-period of `clk_signal`; ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `alu_data_i`  in  DATA_W  datapath ALU result, low byte.
- `wr_en_i`  in  1  output-latch write strobe.
- `gpio_pad_i`  in  DATA_W  raw asynchronous input pins.
- `clr_i`  in  1  clears all change flags.
- `gpio_o`  out  DATA_W  registered output pins.
- `gpio_in_o`  out  DATA_W  debounced input value, to the datapath GPIO input.
- `change_o`  out  DATA_W  sticky per-bit "debounced value changed" flags.
- `clk_signal`  out  1  divided square wave, period 2·DIV_MAX.
- `tick_o`  out  1  one-cycle pulse coincident with each rising edge of `clk_signal`.

## Operation
- **Reset** (`reset`=0 at an edge): every output is 0. Internally, both sync stages, all debounce counters, the stable values, the divider counter, `clk_signal` and `tick_o` are 0. Reset has priority over every other input, including mid-debounce or mid-divide.
- **Output latch:**
  - On an edge with `wr_en_i`=1, `gpio_o` ← `alu_data_i`.
  - Otherwise `gpio_o` holds.
  - No other path modifies it.
- **Input synchronizer:** two flops per bit, `s1` ← pad, then `s2` ← `s1`. No reset bypass.
- **Debounce, per bit, independent;** counter width clog2(DEB_CYCLES):
  - If `s2` == stable: counter ← 0.
  - Else, if counter == DEB_CYCLES−1: stable ← `s2` and counter ← 0.
  - Else: counter ← counter+1.
  - Any glitch back to the stable value restarts the count from 0.
  - `gpio_in_o` = the stable values.
- **Change flags:**
  - On the edge where a bit's stable value updates, its `change_o` bit ← 1.
  - `clr_i`=1 clears all bits.
  - If a set and `clr_i` occur on the same edge, the set wins for that bit.
- **Divider:**
  - Counter runs 0..DIV_MAX−1. At DIV_MAX−1 it wraps to 0 and `clk_signal` toggles.
  - `tick_o` ← 1 on the same edge where `clk_signal` toggles 0→1; otherwise `tick_o` ← 0.
  - `clk_signal` is a data signal and never clocks logic.

## Timing
- **Write latency:** `gpio_o` shows `alu_data_i` 1 edge after the strobe edge.
- **Input latency:** a pad level held from before edge 0 appears on `gpio_in_o` after edge DEB_CYCLES+1, i.e. DEB_CYCLES+2 edges in total (18 at default). `change_o` sets on that same edge.
- **Rejected pulses:** a pad pulse shorter than DEB_CYCLES cycles at `s2` never reaches `gpio_in_o`.
- **First divider edge:** after reset release, `clk_signal` first rises at edge DIV_MAX, with `tick_o` high during the following cycle.
- **Divider cadence:** `tick_o` then pulses every 2·DIV_MAX edges.
- **DIV_MAX=1 case:** `clk_signal` toggles every edge and `tick_o` pulses every 2nd edge.
- **Simultaneous events:** write, debounce update, flag set/clear and divider wrap are independent; any combination on one edge takes effect as described above.
- No combinational paths from inputs to outputs.

## Structure
- Shared package/include `gpio_pkg` holds the `GPIO_W`=8 and default `DEB_CYCLES` / `DIV_MAX` constants. The datapath uses the same width constant.
- Sub-module `debounce_bit` contains the sync pair, counter and stable flop for one bit. It has a `changed` pulse output and is instantiated DATA_W times via generate.
- Divider and output latch stay in the top module.

## Test plan
Bench parameters: DEB_CYCLES=4, DIV_MAX=4.
1. Reset held 3 cycles with pads=8'hFF and `alu_data_i`=8'hAA → all outputs 0 while in reset. After release: `gpio_in_o`=8'hFF at edge 6, `change_o`=8'hFF.
2. `alu_data_i`=8'h5C with `wr_en_i` for 1 cycle, then `alu_data_i`=8'h00 with `wr_en_i`=0 → `gpio_o`=8'h5C after the strobe edge and holds.
3. Pad bit0 0→1 held → `gpio_in_o[0]`=1 exactly 6 edges later and `change_o[0]`=1. Pad bit1 pulsed for 3 cycles → `gpio_in_o[1]` and `change_o[1]` stay 0.
4. `clr_i` asserted on the same edge bit2's debounce completes → `change_o[2]`=1 and all other bits 0. One cycle later `clr_i` alone → 8'h00.
5. After reset release → `clk_signal` rises at edge 4, falls at edge 8, rises at edge 12. `tick_o` is high only in the cycles following edges 4 and 12.
6. Reset asserted during a debounce count (pad changed 3 cycles earlier) and mid-divide → all outputs 0 next edge. After release the full latency is re-measured from zero.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO constants and helpers used by the I/O unit and the datapath.
package gpio_pkg;

  localparam int unsigned GPIO_W         = 8;
  localparam int unsigned DEB_CYCLES_DEF = 16;
  localparam int unsigned DIV_MAX_DEF    = 25_000_000;

  typedef logic [GPIO_W-1:0] gpio_word_t;

  // Counter width able to hold 0..max_count-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? 32'($clog2(max_count)) : 32'(1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One GPIO input bit: two-flop synchronizer, stability counter and accepted value.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_i,
  output logic stable_o,
  output logic changed_c
);

  localparam int unsigned          CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles where the synchronized pad differs from the accepted value.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    changed_c = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d  = s2_q;
      cnt_d     = '0;
      changed_c = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= pad_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/gpio_io_unit.sv
// GPIO boundary unit: output latch, debounced inputs with sticky change flags,
// and a slow square-wave divider with a rising-edge tick.
module gpio_io_unit
  import gpio_pkg::*;
#(
  parameter int unsigned DATA_W     = GPIO_W,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned DIV_MAX    = DIV_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] gpio_pad_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] gpio_o,
  output logic [DATA_W-1:0] gpio_in_o,
  output logic [DATA_W-1:0] change_o,
  output logic              clk_signal,
  output logic              tick_o
);

  localparam int unsigned      DIV_W    = cnt_width(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

  logic [DATA_W-1:0] stable_w;
  logic [DATA_W-1:0] changed_c;

  logic [DATA_W-1:0] gpio_q;
  logic [DATA_W-1:0] gpio_d;
  logic [DATA_W-1:0] change_q;
  logic [DATA_W-1:0] change_d;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic              div_wrap;
  logic              clk_sig_q;
  logic              clk_sig_d;
  logic              tick_q;
  logic              tick_d;

  for (genvar i = 0; i < DATA_W; i++) begin : g_deb
    debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .pad_i    (gpio_pad_i[i]),
      .stable_o (stable_w[i]),
      .changed_c(changed_c[i])
    );
  end

  // Next state for latch, change flags (set beats clear) and divider.
  always_comb begin
    gpio_d    = wr_en_i ? alu_data_i : gpio_q;
    change_d  = changed_c | (clr_i ? '0 : change_q);
    div_wrap  = (div_q == DIV_LAST);
    div_d     = div_wrap ? '0 : div_q + DIV_W'(1);
    clk_sig_d = clk_sig_q ^ div_wrap;
    tick_d    = div_wrap & ~clk_sig_q;
  end

  // Registered outputs and divider state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_q    <= '0;
      change_q  <= '0;
      div_q     <= '0;
      clk_sig_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      gpio_q    <= gpio_d;
      change_q  <= change_d;
      div_q     <= div_d;
      clk_sig_q <= clk_sig_d;
      tick_q    <= tick_d;
    end
  end

  assign gpio_o     = gpio_q;
  assign gpio_in_o  = stable_w;
  assign change_o   = change_q;
  assign clk_signal = clk_sig_q;
  assign tick_o     = tick_q;

endmodule

// File: tb/tb_gpio_io_unit.sv
// Directed bench for gpio_io_unit with DEB_CYCLES=4, DIV_MAX=4.
module tb_gpio_io_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_data_i;
  logic       wr_en_i;
  logic [7:0] gpio_pad_i;
  logic       clr_i;
  logic [7:0] gpio_o;
  logic [7:0] gpio_in_o;
  logic [7:0] change_o;
  logic       clk_signal;
  logic       tick_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       wr;
    logic [7:0] alu;
    logic [7:0] exp_gpio;
  } latch_vec_t;

  latch_vec_t vecs [7];

  always #5 clk = ~clk;

  gpio_io_unit #(
    .DATA_W    (8),
    .DEB_CYCLES(4),
    .DIV_MAX   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_data_i(alu_data_i),
    .wr_en_i   (wr_en_i),
    .gpio_pad_i(gpio_pad_i),
    .clr_i     (clr_i),
    .gpio_o    (gpio_o),
    .gpio_in_o (gpio_in_o),
    .change_o  (change_o),
    .clk_signal(clk_signal),
    .tick_o    (tick_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gpio_o"},     32'(gpio_o),     32'h0);
    check({tag, " gpio_in_o"},  32'(gpio_in_o),  32'h0);
    check({tag, " change_o"},   32'(change_o),   32'h0);
    check({tag, " clk_signal"}, 32'(clk_signal), 32'h0);
    check({tag, " tick_o"},     32'(tick_o),     32'h0);
  endtask

  // Edges 1..13 after reset release: divider waveform plus input latency.
  task automatic post_release(input logic [7:0] exp_in, input string tag);
    for (int k = 1; k <= 13; k++) begin
      step(1);
      check($sformatf("%s clk_signal e%0d", tag, k), 32'(clk_signal), 32'((k / 4) % 2));
      check($sformatf("%s tick_o e%0d", tag, k), 32'(tick_o), 32'((k % 8) == 4));
      if (k == 5) begin
        check($sformatf("%s gpio_in_o e5", tag), 32'(gpio_in_o), 32'h0);
        check($sformatf("%s change_o e5", tag),  32'(change_o),  32'h0);
      end
      if (k == 6) begin
        check($sformatf("%s gpio_in_o e6", tag), 32'(gpio_in_o), 32'(exp_in));
        check($sformatf("%s change_o e6", tag),  32'(change_o),  32'(exp_in));
      end
    end
    check({tag, " gpio_o held 0"}, 32'(gpio_o), 32'h0);
  endtask

  initial begin
    vecs[0] = '{wr: 1'b1, alu: 8'h5C, exp_gpio: 8'h5C};
    vecs[1] = '{wr: 1'b0, alu: 8'h00, exp_gpio: 8'h5C};
    vecs[2] = '{wr: 1'b0, alu: 8'hFF, exp_gpio: 8'h5C};
    vecs[3] = '{wr: 1'b1, alu: 8'hA5, exp_gpio: 8'hA5};
    vecs[4] = '{wr: 1'b1, alu: 8'h00, exp_gpio: 8'h00};
    vecs[5] = '{wr: 1'b1, alu: 8'h33, exp_gpio: 8'h33};
    vecs[6] = '{wr: 1'b0, alu: 8'hC3, exp_gpio: 8'h33};

    // Reset held three cycles with pads high and a write pending.
    reset      = 1'b0;
    gpio_pad_i = 8'hFF;
    alu_data_i = 8'hAA;
    wr_en_i    = 1'b1;
    clr_i      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_all_zero($sformatf("reset%0d", i));
    end

    reset   = 1'b1;
    wr_en_i = 1'b0;
    post_release(8'hFF, "rel1");

    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("clr after rel1", 32'(change_o), 32'h0);

    // Output latch table.
    foreach (vecs[i]) begin
      wr_en_i    = vecs[i].wr;
      alu_data_i = vecs[i].alu;
      step(1);
      check($sformatf("latch vec%0d", i), 32'(gpio_o), 32'(vecs[i].exp_gpio));
    end
    wr_en_i = 1'b0;

    // Bring all inputs low and clear flags.
    gpio_pad_i = 8'h00;
    step(8);
    check("pads low", 32'(gpio_in_o), 32'h0);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("clr flags", 32'(change_o), 32'h0);

    // Bit0 held high, bit1 pulsed for three cycles.
    gpio_pad_i = 8'h03;
    step(3);
    gpio_pad_i = 8'h01;
    step(2);
    check("bit0 e5 gpio_in", 32'(gpio_in_o), 32'h0);
    step(1);
    check("bit0 e6 gpio_in", 32'(gpio_in_o), 32'h01);
    check("bit0 e6 change",  32'(change_o),  32'h01);
    step(4);
    check("bit1 rejected gpio_in", 32'(gpio_in_o), 32'h01);
    check("bit1 rejected change",  32'(change_o),  32'h01);

    // Clear coincides with bit2 acceptance: set wins for bit2 only.
    gpio_pad_i = 8'h05;
    step(5);
    check("bit2 e5 gpio_in", 32'(gpio_in_o), 32'h01);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("set beats clr change", 32'(change_o),  32'h04);
    check("bit2 e6 gpio_in",      32'(gpio_in_o), 32'h05);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("clr alone", 32'(change_o), 32'h00);

    // Reset mid-debounce and mid-divide, then full latency from zero.
    gpio_pad_i = 8'h0D;
    step(3);
    reset = 1'b0;
    step(1);
    check_all_zero("midreset");
    reset = 1'b1;
    post_release(8'h0D, "rel2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
